// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbiter: scheduler
//               state encoding and the fixed geometry of the downstream
//               UART_TX frame.
// Contents    : state_t          - arbiter scheduler states
//               UART_FRAME_CYCLES - transmitter occupancy after t is sampled
//               UART_DATA_W       - payload width of one frame
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // One BUFF cycle plus start bit, eight data bits, stop bit and one
    // trailing line cycle inside the transmitter.
    localparam int UART_FRAME_CYCLES = 12;
    localparam int UART_DATA_W       = 8;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first valid
//               requester found searching upward from ptr, with wrap-around.
// Ports       : req_valid  in  N_REQ  - request vector
//               ptr        in  IDW    - search start index (< N_REQ)
//               grant      out N_REQ  - one-hot grant (all zero if none)
//               grant_idx  out IDW    - encoded index of the grant
//               any_valid  out 1      - at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             any_valid
);

    int             w_j;
    logic [IDW-1:0] w_idx;
    logic           w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_j       = 0;
        w_idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Candidate index ptr+i folded back into 0..N_REQ-1.
            w_j = int'(ptr) + i;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            w_idx = IDW'(w_j);
            if (!w_found && req_valid[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

    assign any_valid = |req_valid;

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin scheduler sharing one UART_TX among N_REQ byte
//               producers. Accepts one byte per frame via valid/ready, pulses
//               the transmitter start and holds its data for the frame, and
//               times the frame itself since the transmitter has no busy flag.
// Ports       : sck        in  1        - clock
//               rst        in  1        - asynchronous active-high reset
//               req_valid  in  N_REQ    - requester i has a byte
//               req_data   in  8*N_REQ  - byte i at [8i+7:8i]
//               req_ready  out N_REQ    - one-hot accept (IDLE only)
//               tx_start   out 1        - transmitter t, one-cycle pulse
//               tx_data    out 8        - transmitter data, held per frame
//               busy       out 1        - high outside IDLE
//               grant_id   out IDW      - owner of the current frame
//               frame_done out 1        - pulse on last occupancy cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int FRAME_CYCLES = UART_FRAME_CYCLES,
    parameter  int GAP_CYCLES   = 0,
    localparam int IDW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         sck,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_start,
    output logic [UART_DATA_W-1:0]       tx_data,
    output logic                         busy,
    output logic [IDW-1:0]               grant_id,
    output logic                         frame_done
);

    localparam int             CW         = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0]  c_CNT_PRE  = CW'(FRAME_CYCLES - 2);
    localparam logic [7:0]     c_GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t                 state_q;
    logic [IDW-1:0]         ptr_q;
    logic [IDW-1:0]         ptr_d;
    logic [IDW-1:0]         grant_id_q;
    logic [UART_DATA_W-1:0] tx_data_q;
    logic [CW-1:0]          cnt_q;
    logic [7:0]             gap_q;
    logic                   tx_start_q;
    logic                   frame_done_q;

    logic [N_REQ-1:0]       w_grant;
    logic [IDW-1:0]         w_pick;
    logic                   w_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (w_grant),
        .grant_idx (w_pick),
        .any_valid (w_any)
    );

    // Pointer moves just past the winner so it becomes lowest priority.
    assign ptr_d = (w_pick == IDW'(N_REQ - 1)) ? '0 : w_pick + IDW'(1);

    // Ready is suppressed while rst is held so no handshake can appear to
    // complete on an edge the state machine ignores.
    assign req_ready = ((state_q == IDLE) && !rst) ? w_grant : '0;

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_any) begin
                        tx_data_q  <= req_data[UART_DATA_W*int'(w_pick) +: UART_DATA_W];
                        grant_id_q <= w_pick;
                        ptr_q      <= ptr_d;
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    // Registered pulse: raise one cycle early so it is
                    // visible exactly on the final occupancy cycle.
                    if (cnt_q == c_CNT_PRE) begin
                        frame_done_q <= 1'b1;
                    end
                    if (cnt_q == c_CNT_LAST) begin
                        cnt_q   <= '0;
                        gap_q   <= '0;
                        state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (gap_q == c_GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_id_q;
    assign frame_done = frame_done_q;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `UART_TX` transmitter among `N_REQ` byte producers. It accepts one byte per frame from a requester through a valid/ready handshake and drives the transmitter's `t` and `data` inputs. It tracks the transmitter's fixed frame length, because the transmitter has no busy output, and never issues a new start before the current frame has left the line. It sits directly in front of `UART_TX`, in the same `sck` domain.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `FRAME_CYCLES`, 12: transmitter occupancy after `t` is sampled (1 BUFF cycle + 11 TRANSMIT cycles). Must be ≥ 12.
- `GAP_CYCLES`, 0: extra idle cycles (line held at 1) between frames. Range 0..255.
- `IDW`, derived: max(1, clog2(N_REQ)).
- Ports:
  - `sck` in 1: clock. Single clock domain.
  - `rst` in 1: reset, asynchronous, active-high.
  - `req_valid` in N_REQ: requester i has a byte.
  - `req_data` in 8*N_REQ: byte i is at bits [8i+7:8i].
  - `req_ready` out N_REQ: one-hot accept. Combinational from registered state and `req_valid`.
  - `tx_start` out 1: connects to transmitter `t`. One-cycle pulse.
  - `tx_data` out 8: connects to transmitter `data`. Held stable for the whole frame.
  - `busy` out 1: high in every state except IDLE.
  - `grant_id` out IDW: index of the requester that owns the current frame.
  - `frame_done` out 1: one-cycle pulse on the last occupancy cycle.

## Operation
- Reset values:
  - state = IDLE
  - `tx_start`, `frame_done`, `busy` = 0
  - `tx_data` = 8'h00
  - `grant_id` = 0
  - round-robin pointer = 0
  - counters = 0
- State IDLE:
  - If any `req_valid` is high, grant the first valid index found searching upward from the pointer, with wrap-around.
  - `req_ready[g]` = 1 in this cycle only. The handshake completes on that edge.
  - On that edge: latch `req_data[g]` into `tx_data`, set `grant_id` = g, set pointer = (g+1) mod N_REQ, go to START.
  - If no `req_valid` is high, `req_ready` = 0 and the pointer is unchanged.
- State START:
  - `tx_start` = 1 for exactly one cycle, then go to HOLD with cnt = 0.
- State HOLD:
  - cnt increments every cycle.
  - When cnt = FRAME_CYCLES−1: assert `frame_done` and clear cnt.
    - If GAP_CYCLES = 0, go to IDLE.
    - Otherwise go to GAP.
- State GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
- `req_ready` is 0 in every state except IDLE. A requester that drops `req_valid` before it is granted loses nothing.
- Changes on `req_data` after acceptance do not affect `tx_data`.
- Counter widths:
  - cnt: clog2(FRAME_CYCLES) bits.
  - gap counter: 8 bits.
  - Neither counter wraps inside a frame.
- Reset mid-frame: the block returns to IDLE immediately and `tx_start` is deasserted. The system asserts `rst` whenever the transmitter's `rst_n` is low, so the two blocks stay aligned.

## Timing
- Let the accept edge end cycle 0.
  - Cycle 1 (START): `tx_start` = 1.
  - Cycle 2: transmitter is in BUFF and captures `tx_data`.
  - Cycles 3..13: start bit, data LSB first, stop bit on TX.
  - HOLD spans cycles 2..13. `frame_done` is high in cycle 13.
  - With GAP_CYCLES = 0: IDLE in cycle 14, the next accept can complete at the end of cycle 14, and the next `tx_start` is in cycle 15.
- Issue-to-issue period = 1 + 1 + FRAME_CYCLES + GAP_CYCLES cycles (14 with defaults).
- Latency from `req_valid` rising to the start bit on TX: 3 cycles when the block is idle.
- If several requesters are valid at once, exactly one is granted per frame. With every requester continuously valid, the grant order is strictly rotating, e.g. 0,1,2,3,0 for N_REQ = 4.

## Structure
- Package `uart_pkg` holds:
  - state encoding: IDLE, START, HOLD, GAP
  - `UART_FRAME_CYCLES` = 12
  - `UART_DATA_W` = 8
- Sub-module `rr_pick`: purely combinational. Inputs are `req_valid` and the pointer; outputs are the one-hot grant and the encoded index. It holds no state; the pointer register lives in the top block.

## Test plan
- Single request: after reset, `req_valid[2]` = 1 with byte 8'hA5 → `req_ready[2]` pulses in cycle 0, `tx_start` in cycle 1, TX carries bits 0,1,0,1,0,0,1,0,1,1 over cycles 3..12 then stop bit, `frame_done` in cycle 13, `grant_id` = 2.
- All requesters valid continuously with bytes 8'h10..8'h13 → frames go out in order 10,11,12,13,10, one `tx_start` every 14 cycles, no overlap.
- Requester 1 changes `req_data` from 8'h3C to 8'hFF in cycle 2 → TX still shifts out 8'h3C.
- GAP_CYCLES = 3 with back-to-back requests → issue period of 17 cycles, TX = 1 throughout each gap.
- `rst` pulsed in cycle 6 of a frame → all outputs return to reset values in the same cycle. After release, a pending request is re-granted starting from index 0.
- Requester 3 drops `req_valid` while requester 0 is transmitting → requester 3 is never granted, and the pointer advances only on real grants.
